// File: rtl/alu_seq_if.sv
// Handshake bundle between the datapath sequencer (master) and the ALU (slave).
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             cf;
  logic             bf;
  logic             vf;
  logic             zf;
  logic             sf;
  logic             pf;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, y, cf, bf, vf, zf, sf, pf
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, y, cf, bf, vf, zf, sf, pf
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, a single-entry result register,
// a persistent carry for multi-word ADC/SBC chains and a shift-add MUL.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | ready for a new op (subject to result-register backpressure)
// ST_MUL  | iterating one partial product per cycle, in_ready held low
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);
  localparam int             MSB = WIDTH - 1;
  localparam int             CW  = $clog2(WIDTH);
  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_INC = 4'b0110;
  localparam logic [3:0] OP_DEC = 4'b0111;
  localparam logic [3:0] OP_SHL = 4'b1000;
  localparam logic [3:0] OP_SHR = 4'b1001;
  localparam logic [3:0] OP_ROL = 4'b1010;
  localparam logic [3:0] OP_ROR = 4'b1011;
  localparam logic [3:0] OP_ADC = 4'b1100;
  localparam logic [3:0] OP_SBC = 4'b1101;
  localparam logic [3:0] OP_CMP = 4'b1110;
  localparam logic [3:0] OP_MUL = 4'b1111;

  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a, b;
  logic [3:0]       op;
  logic             in_ready, accept, is_mul, is_logic;
  logic             mul_busy, mul_step, mul_done;

  logic [WIDTH-1:0] mcand, acc_hi, acc_lo;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   msum;
  logic [WIDTH-1:0] mhi_nxt, mlo_nxt;

  logic [WIDTH:0]   s_add, s_sub, s_inc, s_dec, s_adc, s_sbc;
  logic [WIDTH-1:0] alu_y, flag_src;
  logic             alu_cf, alu_bf, alu_vf, alu_zf, alu_sf, alu_pf;

  logic [WIDTH-1:0] res_y;
  logic             res_cf, res_bf, res_vf, res_zf, res_sf, res_pf;
  logic             load, c_upd;

  logic             out_valid, c_reg;
  logic [WIDTH-1:0] y_q;
  logic             cf_q, bf_q, vf_q, zf_q, sf_q, pf_q;

  assign a        = bus.a;
  assign b        = bus.b;
  assign op       = bus.op;
  assign is_mul   = (op == OP_MUL);
  assign is_logic = (op == OP_AND) || (op == OP_OR) || (op == OP_XOR) || (op == OP_NOT);
  assign in_ready = ~mul_busy & (~out_valid | bus.out_ready);
  assign accept   = bus.in_valid & in_ready;

  // State register for the MUL sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and MUL control; the last step coincides with the result load.
  always_comb begin
    state_nxt = state;
    mul_busy  = 1'b0;
    mul_step  = 1'b0;
    mul_done  = 1'b0;
    case (state)
      ST_IDLE: if (accept && is_mul) state_nxt = ST_MUL;
      ST_MUL: begin
        mul_busy = 1'b1;
        mul_step = 1'b1;
        if (cnt == '0) begin
          mul_done  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // One shift-add step: {hi,lo} = ({hi + (lo[0] ? mcand : 0), lo}) >> 1.
  always_comb begin
    msum    = {1'b0, acc_hi} + {1'b0, {WIDTH{acc_lo[0]}} & mcand};
    mhi_nxt = msum[WIDTH:1];
    mlo_nxt = {msum[0], acc_lo[MSB:1]};
  end

  // Multiplier operand/accumulator registers; cnt counts down to the final step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
    end else if (accept && is_mul) begin
      mcand  <= a;
      acc_hi <= '0;
      acc_lo <= b;
      cnt    <= CW'(WIDTH - 1);
    end else if (mul_step) begin
      acc_hi <= mhi_nxt;
      acc_lo <= mlo_nxt;
      cnt    <= cnt - 1'b1;
    end
  end

  // Single-cycle ALU; CMP reports zf/sf/pf from the difference while y keeps a.
  always_comb begin
    s_add  = {1'b0, a} + {1'b0, b};
    s_sub  = {1'b0, a} + {1'b0, ~b} + ONE;
    s_inc  = {1'b0, a} + ONE;
    s_dec  = {1'b0, a} + {1'b0, {WIDTH{1'b1}}};
    s_adc  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_reg};
    s_sbc  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, c_reg};
    alu_y  = '0;
    alu_cf = 1'b0;
    alu_bf = 1'b0;
    alu_vf = 1'b0;
    case (op)
      OP_ADD: begin
        alu_y  = s_add[MSB:0];
        alu_cf = s_add[WIDTH];
        alu_vf = ~(a[MSB] ^ b[MSB]) & (a[MSB] ^ s_add[MSB]);
      end
      OP_SUB, OP_CMP: begin
        alu_y  = (op == OP_CMP) ? a : s_sub[MSB:0];
        alu_cf = s_sub[WIDTH];
        alu_bf = ~s_sub[WIDTH];
        alu_vf = (a[MSB] ^ b[MSB]) & (a[MSB] ^ s_sub[MSB]);
      end
      OP_AND: alu_y = a & b;
      OP_OR:  alu_y = a | b;
      OP_XOR: alu_y = a ^ b;
      OP_NOT: alu_y = ~a;
      OP_INC: begin
        alu_y  = s_inc[MSB:0];
        alu_cf = s_inc[WIDTH];
        alu_vf = ~a[MSB] & s_inc[MSB];
      end
      OP_DEC: begin
        alu_y  = s_dec[MSB:0];
        alu_cf = s_dec[WIDTH];
        alu_bf = ~s_dec[WIDTH];
        alu_vf = a[MSB] & ~s_dec[MSB];
      end
      OP_SHL: begin
        alu_y  = {a[MSB-1:0], 1'b0};
        alu_cf = a[MSB];
        alu_vf = a[MSB] ^ a[MSB-1];
      end
      OP_SHR: begin
        alu_y  = {1'b0, a[MSB:1]};
        alu_cf = a[0];
      end
      OP_ROL: begin
        alu_y  = {a[MSB-1:0], a[MSB]};
        alu_cf = a[MSB];
      end
      OP_ROR: begin
        alu_y  = {a[0], a[MSB:1]};
        alu_cf = a[0];
      end
      OP_ADC: begin
        alu_y  = s_adc[MSB:0];
        alu_cf = s_adc[WIDTH];
        alu_vf = ~(a[MSB] ^ b[MSB]) & (a[MSB] ^ s_adc[MSB]);
      end
      OP_SBC: begin
        alu_y  = s_sbc[MSB:0];
        alu_cf = s_sbc[WIDTH];
        alu_bf = ~s_sbc[WIDTH];
        alu_vf = (a[MSB] ^ b[MSB]) & (a[MSB] ^ s_sbc[MSB]);
      end
      default: alu_y = '0;
    endcase
    flag_src = (op == OP_CMP) ? s_sub[MSB:0] : alu_y;
    alu_zf   = (flag_src == '0);
    alu_sf   = flag_src[MSB];
    alu_pf   = ~^flag_src;
  end

  // Select what loads into the result register: finished MUL or the single-cycle ALU.
  always_comb begin
    load  = mul_done | (accept & ~is_mul);
    c_upd = mul_done | (accept & ~is_mul & ~is_logic);
    if (mul_done) begin
      res_y  = mlo_nxt;
      res_cf = |mhi_nxt;
      res_bf = 1'b0;
      res_vf = |mhi_nxt;
      res_zf = (mlo_nxt == '0);
      res_sf = mlo_nxt[MSB];
      res_pf = ~^mlo_nxt;
    end else begin
      res_y  = alu_y;
      res_cf = alu_cf;
      res_bf = alu_bf;
      res_vf = alu_vf;
      res_zf = alu_zf;
      res_sf = alu_sf;
      res_pf = alu_pf;
    end
  end

  // Result register and carry chain; a consume without a new load drops out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      c_reg     <= 1'b0;
      y_q       <= '0;
      cf_q      <= 1'b0;
      bf_q      <= 1'b0;
      vf_q      <= 1'b0;
      zf_q      <= 1'b0;
      sf_q      <= 1'b0;
      pf_q      <= 1'b0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        y_q       <= res_y;
        cf_q      <= res_cf;
        bf_q      <= res_bf;
        vf_q      <= res_vf;
        zf_q      <= res_zf;
        sf_q      <= res_sf;
        pf_q      <= res_pf;
      end else if (out_valid && bus.out_ready) begin
        out_valid <= 1'b0;
      end
      if (c_upd) c_reg <= res_cf;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.y         = y_q;
  assign bus.cf        = cf_q;
  assign bus.bf        = bf_q;
  assign bus.vf        = vf_q;
  assign bus.zf        = zf_q;
  assign bus.sf        = sf_q;
  assign bus.pf        = pf_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8) with a result scoreboard queue.
// Flags are compared packed as {cf,bf,vf,zf,sf,pf}.
module tb_alu_seq;
  localparam int W = 8;

  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, AND = 4'b0010, OR  = 4'b0011;
  localparam logic [3:0] XOR = 4'b0100, NOT = 4'b0101, INC = 4'b0110, DEC = 4'b0111;
  localparam logic [3:0] SHL = 4'b1000, SHR = 4'b1001, ROL = 4'b1010, ROR = 4'b1011;
  localparam logic [3:0] ADC = 4'b1100, SBC = 4'b1101, CMP = 4'b1110, MUL = 4'b1111;

  typedef struct packed {
    logic [W-1:0] y;
    logic [5:0]   f;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  res_t sb[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] flags_now();
    return {bus.cf, bus.bf, bus.vf, bus.zf, bus.sf, bus.pf};
  endfunction

  task automatic push(input logic [W-1:0] y, input logic [5:0] f);
    res_t r;
    r.y = y;
    r.f = f;
    sb.push_back(r);
  endtask

  // Called at a negedge: present the op, wait for in_ready, let the edge accept it.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("issue_ready", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Wait for out_valid at a negedge and compare against the scoreboard head.
  task automatic collect(input string tag);
    res_t r;
    int n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, bus.out_valid, 1);
    chk({tag, "_sb"}, (sb.size() != 0), 1);
    if (sb.size() != 0) begin
      r = sb.pop_front();
      chk({tag, "_y"}, bus.y, r.y);
      chk({tag, "_f"}, flags_now(), r.f);
    end
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] y, input logic [5:0] f);
    push(y, f);
    issue(op, a, b);
    collect(tag);
  endtask

  task automatic run_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] y, input logic [5:0] f);
    int lat = 0;
    int busy_bad = 0;
    push(y, f);
    issue(MUL, a, b);
    if (bus.in_ready) busy_bad++;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (!bus.out_valid && bus.in_ready) busy_bad++;
    end while (!bus.out_valid && lat < 40);
    chk({tag, "_latency"}, lat, W);
    chk({tag, "_busy"}, busy_bad, 0);
    collect(tag);
  endtask

  initial begin
    res_t r;
    int stale;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.a = '0;
    bus.b = '0;
    bus.op = '0;

    #1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_y", bus.y, 0);
    chk("rst_f", flags_now(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_in_ready", bus.in_ready, 1);
    @(negedge clk);

    run("inc_ff", INC, 8'hFF, 8'h00, 8'h00, 6'b100101);
    run("inc_7f", INC, 8'h7F, 8'h00, 8'h80, 6'b001010);
    run("dec_00", DEC, 8'h00, 8'h00, 8'hFF, 6'b010011);
    run("shr_01", SHR, 8'h01, 8'h00, 8'h00, 6'b100101);
    run("rol_80", ROL, 8'h80, 8'h00, 8'h01, 6'b100000);
    run("not_0f", NOT, 8'h0F, 8'h00, 8'hF0, 6'b000011);
    run("xor",    XOR, 8'hFF, 8'h0F, 8'hF0, 6'b000011);
    run("or",     OR,  8'h0C, 8'h30, 8'h3C, 6'b000001);

    run("add_ff", ADD, 8'hFF, 8'h01, 8'h00, 6'b100101);
    run("adc_c1", ADC, 8'h10, 8'h20, 8'h31, 6'b000000);
    run("add_7f", ADD, 8'h7F, 8'h01, 8'h80, 6'b001010);
    run("sub",    SUB, 8'h05, 8'h07, 8'hFE, 6'b010010);
    run("sbc_c0", SBC, 8'h00, 8'h00, 8'hFF, 6'b010011);

    run_mul("mul_ovf", 8'h10, 8'h10, 8'h00, 6'b101101);
    run_mul("mul_2d",  8'h0F, 8'h03, 8'h2D, 6'b000001);

    // Backpressure: SHL result held while a ROR waits behind it.
    @(negedge clk);
    bus.out_ready = 1'b0;
    push(8'h02, 6'b101000);
    issue(SHL, 8'h81, 8'h00);
    bus.op = ROR;
    bus.a = 8'h01;
    bus.b = 8'h00;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_y", bus.y, 8'h02);
      chk("bp_f", flags_now(), 6'b101000);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    r = sb.pop_front();
    chk("bp_shl_y", bus.y, r.y);
    chk("bp_shl_f", flags_now(), r.f);
    push(8'h80, 6'b100010);
    bus.out_ready = 1'b1;
    #1 chk("bp_release_ready", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    collect("bp_ror");

    run("cmp_eq",  CMP, 8'h33, 8'h33, 8'h33, 6'b100101);
    run("and_z",   AND, 8'hF0, 8'h0F, 8'h00, 6'b000101);
    run("adc_keep", ADC, 8'h00, 8'h00, 8'h01, 6'b000000);

    // Reset in the third cycle of a MUL abandons it and clears carry.
    run("add_c1",  ADD, 8'hFF, 8'h02, 8'h01, 6'b100000);
    issue(MUL, 8'h0F, 8'h03);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid", bus.out_valid, 0);
    chk("mrst_y", bus.y, 0);
    chk("mrst_f", flags_now(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("mrst_in_ready", bus.in_ready, 1);
    stale = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    chk("mrst_stale", stale, 0);
    run("adc_after_rst", ADC, 8'h00, 8'h00, 8'h00, 6'b000101);

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor of the team's 4-bit combinational ALU. Data and result are WIDTH bits.
- Inputs and results use valid/ready handshakes, with a single-entry result register.
- Adds a persistent carry register for multi-word ADC/SBC chains and an iterative multi-cycle MUL.
- Sits between the datapath sequencer (issue side) and the register-file writeback (result side).

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 4..32.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request valid
- in_ready  out  1  block can accept an operation this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  4  opcode
- out_valid  out  1  result register holds an unconsumed result
- out_ready  in  1  consumer accepts the result
- y  out  WIDTH  result
- cf, bf, vf, zf, sf, pf  out  1 each  carry, borrow, signed overflow, zero, sign, even parity

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, y=0, all flags 0.
  - Internal carry register c_reg=0, MUL state idle.
  - in_ready=1 after release.
  - Reset mid-MUL abandons the operation; no result is produced.
- Accept: occurs on a rising edge with in_valid & in_ready. a, b and op are captured at that edge.
- in_ready = ~mul_busy & (~out_valid | out_ready). A result may be consumed and a new op accepted on the same edge.
- Result hold: out_valid stays high, with y and flags stable, until an edge with out_ready=1.
- Latency:
  - Single-cycle ops: result loads at the accept edge, so out_valid is high the following cycle.
  - MUL: mul_busy for WIDTH cycles after accept; result loads at edge accept+WIDTH. in_ready=0 throughout.
- Opcodes (n=WIDTH, arithmetic done in n+1 bits):
  - 0000 ADD: y=a+b; cf=carry out; vf=signed overflow.
  - 0001 SUB: y=a+~b+1; cf=carry out; bf=~cf; vf=(a[n-1]^b[n-1])&(a[n-1]^y[n-1]).
  - 0010 AND, 0011 OR, 0100 XOR, 0101 NOT(a).
  - 0110 INC: y=a+1; cf and vf as for ADD.
  - 0111 DEC: y=a+all-ones; cf=carry out; bf=~cf; vf=a[n-1]&~y[n-1].
  - 1000 SHL: y={a[n-2:0],0}; cf=a[n-1]; vf=a[n-1]^y[n-1].
  - 1001 SHR (logical): cf=a[0].
  - 1010 ROL: cf=a[n-1].
  - 1011 ROR: cf=a[0].
  - 1100 ADC: y=a+b+c_reg; cf and vf as for ADD.
  - 1101 SBC: y=a+~b+c_reg, where c_reg=1 means no borrow; bf=~cf; vf as for SUB.
  - 1110 CMP: y=a (unchanged); flags cf/bf/vf from a-b; zf=(a==b); sf=(a-b)[n-1]; pf from a-b.
  - 1111 MUL (unsigned, shift-add, one partial product per cycle): y=low n bits of a*b; cf=vf=(high n bits != 0).
- Flags not listed for an op are 0.
- zf=(y==0), sf=y[n-1] and pf=~^y for every op except CMP.
- c_reg is updated to the reported cf when a result loads, for every op except AND/OR/XOR/NOT, which leave c_reg unchanged.
- ADC/SBC use the c_reg value as of the accept edge.
- Back-to-back chains are exact: the previous result always loads before the next op is accepted.
- in_valid while in_ready=0 is ignored. The source must hold its request until accepted.

Test Plan (WIDTH=8):
- ADD a=0xFF b=0x01, out_ready=1 -> next cycle y=0x00, cf=1, zf=1, pf=1, vf=0. Then ADC a=0x10 b=0x20 -> y=0x31, cf=0.
- ADD a=0x7F b=0x01 -> y=0x80, vf=1, sf=1, pf=0, cf=0. SUB a=0x05 b=0x07 -> y=0xFE, cf=0, bf=1, sf=1. Then SBC a=0x00 b=0x00 -> y=0xFF, bf=1.
- MUL a=0x10 b=0x10 -> in_ready=0 for 8 cycles; out_valid high exactly 8 edges after accept; y=0x00, cf=vf=1, zf=1. MUL 0x0F*0x03 -> y=0x2D, cf=0.
- Backpressure: out_ready=0 after SHL a=0x81 -> y=0x02, cf=1, vf=1 held stable; in_ready=0; a new in_valid is not accepted until out_ready=1. On that edge a pending op is accepted and the old result retires.
- CMP a=0x33 b=0x33 -> y=0x33, zf=1, cf=1, bf=0. Then AND a=0xF0 b=0x0F -> cf=0, zf=1, c_reg still 1 (verified by ADC 0x00+0x00 -> y=0x01).
- Assert rst_n=0 on cycle 3 of a MUL -> out_valid=0, y=0 and flags 0 immediately. After release in_ready=1, no stale result appears, and ADC 0x00+0x00 -> y=0x00.
